mul_ternary_loader: RTL
=======================

Name: mul_ternary_loader

Overview:
- Upstream feeder for the ternary polynomial multiplier.
- Accepts 32-bit words on a valid/ready stream and unpacks them into the parallel general polynomial (poly_gen) and the ternary polynomial (poly_ter).
- Reduces general coefficients into [0, Q) and validates ternary codes.
- Once both operands are loaded, issues the multiplier start and reset-command handshake, then reports completion.

Parameters:
- PARAM_N, 512, polynomial length; must be a multiple of 16.
- PARAM_Q, 251, modulus; 2^PARAM_LOG_Q < 2*PARAM_Q is required.
- PARAM_LOG_Q, 8, coefficient width; must divide 32.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- load_gen  in  1  pulse; starts loading of poly_gen.
- load_ter  in  1  pulse; starts loading of poly_ter.
- run  in  1  pulse; requests a multiplication.
- in_valid  in  1  input word valid.
- in_data  in  32  input word.
- in_ready  out  1  loader accepts the word this cycle.
- poly_gen  out  PARAM_LOG_Q x PARAM_N  unpacked general coefficients.
- poly_ter  out  2 x PARAM_N  ternary coefficients: 00 = 0, 01 = +1, 11 = -1.
- gen_loaded  out  1  poly_gen complete.
- ter_loaded  out  1  poly_ter complete.
- ter_err  out  1  sticky: an illegal ternary code (10) was received.
- mul_enable  out  1  multiplier enable.
- mul_start  out  1  multiplier start_calc.
- mul_rst_command  out  1  multiplier rst_command.
- mul_ready  in  1  multiplier ready.
- done  out  1  one-cycle pulse when the product is valid.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - state IDLE, word counter 0, in_ready = 0.
  - All poly_gen and poly_ter entries 0.
  - gen_loaded, ter_loaded, ter_err, mul_enable, mul_start, mul_rst_command and done all 0.
  - Reset asserted mid-load or mid-multiply aborts immediately to this state.
- States: IDLE, LOAD_GEN, LOAD_TER, ISSUE, WAIT_BUSY, WAIT_DONE, FINISH.
- IDLE:
  - load_gen -> LOAD_GEN; clears gen_loaded and the counter.
  - Else load_ter -> LOAD_TER; clears ter_loaded and ter_err, and clears the counter.
  - Else run with gen_loaded & ter_loaded & mul_ready -> ISSUE.
  - Any run not meeting that condition is dropped.
  - Priority: load_gen > load_ter > run. Lower-priority commands in the same cycle are dropped.
  - All commands are ignored outside IDLE.
- LOAD_GEN / LOAD_TER handshake:
  - in_ready = 1 in both states.
  - A word is accepted on in_valid & in_ready; the counter increments per accepted word.
  - in_valid = 0 holds state without a timeout.
- Gen packing:
  - Word k carries coefficient k*G + m in bits [m*PARAM_LOG_Q +: PARAM_LOG_Q], where G = 32/PARAM_LOG_Q.
  - Each coefficient c is stored as c - PARAM_Q if c >= PARAM_Q, else c (single conditional subtract).
- Ter packing:
  - Word k carries coefficient 16k + m in bits [2m+1:2m].
  - Code 10 is stored as 00 and sets ter_err.
- Load completion:
  - On acceptance of the last word (PARAM_N/G - 1 for gen, PARAM_N/16 - 1 for ter), the loaded flag is set on the next edge.
  - State returns to IDLE and in_ready falls on that same edge, so no extra word is accepted.
- Multiply sequence:
  - ISSUE: mul_enable = 1 and mul_start = 1 for exactly one cycle, then -> WAIT_BUSY.
  - mul_enable stays 1 from ISSUE until FINISH.
  - WAIT_BUSY: waits for mul_ready = 0, then -> WAIT_DONE.
  - WAIT_DONE: waits for mul_ready = 1, then -> FINISH.
  - FINISH: done = 1 and mul_rst_command = 1 for one cycle; mul_enable = 0; -> IDLE.
- Persistence: loaded flags and polynomial registers persist across runs, so a new poly_ter can be reused with the same poly_gen.
- Output timing: all outputs are registered; poly_gen and poly_ter change only in LOAD states or on reset.

Test Plan:
1. Reset, load_gen, then 128 words with word 0 = 0xFCFB0201 (in_valid always 1) -> poly_gen[0..3] = 1, 2, 0, 1 (251 -> 0, 252 -> 1); in_ready high for exactly 128 cycles; gen_loaded = 1 on the cycle after the 128th accept.
2. load_ter with word 0 = 0x0000_00B7 (codes 11, 01, 11, 10) -> poly_ter[0..3] = 11, 01, 11, 00; ter_err = 1; a subsequent load_ter clears ter_err.
3. Both loaded; run with mul_ready = 1 -> mul_start high exactly 1 cycle. Model mul_ready low 2 cycles later and high 514 cycles later -> done and mul_rst_command pulse 1 cycle after mul_ready rises; state back in IDLE.
4. run with only gen_loaded = 1 -> no mul_start, and the run is not remembered. Also: load_gen and load_ter pulsed in the same cycle -> LOAD_GEN entered, load_ter dropped.
5. Insert random in_valid gaps during a ter load -> identical poly_ter to the gap-free load; no word accepted outside LOAD states.
6. Drive rst = 0 at word 40 of a gen load, and separately during WAIT_DONE -> all outputs return to 0; the next full load behaves as in scenario 1.

Source files
------------

// File: rtl/mul_ternary_loader.sv
// Stream loader for the ternary polynomial multiplier: unpacks 32-bit words into
// the general and ternary operand registers, then sequences the multiplier handshake.
module mul_ternary_loader #(
  parameter int PARAM_N     = 512,
  parameter int PARAM_Q     = 251,
  parameter int PARAM_LOG_Q = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_gen,
  input  logic                   load_ter,
  input  logic                   run,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  output logic [PARAM_LOG_Q-1:0] poly_gen [PARAM_N],
  output logic [1:0]             poly_ter [PARAM_N],
  output logic                   gen_loaded,
  output logic                   ter_loaded,
  output logic                   ter_err,
  output logic                   mul_enable,
  output logic                   mul_start,
  output logic                   mul_rst_command,
  input  logic                   mul_ready,
  output logic                   done
);

  localparam int G         = 32 / PARAM_LOG_Q;
  localparam int GEN_WORDS = PARAM_N / G;
  localparam int TER_WORDS = PARAM_N / 16;
  localparam int MAX_WORDS = (GEN_WORDS > TER_WORDS) ? GEN_WORDS : TER_WORDS;
  localparam int CW        = $clog2(MAX_WORDS + 1);

  localparam logic [CW-1:0]          GEN_LAST = CW'(GEN_WORDS - 1);
  localparam logic [CW-1:0]          TER_LAST = CW'(TER_WORDS - 1);
  localparam logic [PARAM_LOG_Q:0]   Q_EXT    = (PARAM_LOG_Q + 1)'(PARAM_Q);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_GEN,
    S_LOAD_TER,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          gen_loaded_q, gen_loaded_d;
  logic          ter_loaded_q, ter_loaded_d;
  logic          ter_err_q, ter_err_d;
  logic          mul_enable_q, mul_enable_d;
  logic          mul_start_q, mul_start_d;
  logic          mul_rst_command_q, mul_rst_command_d;
  logic          done_q, done_d;

  logic gen_wr;
  logic ter_wr;
  logic ter_bad;

  assign gen_wr = (state_q == S_LOAD_GEN) && in_valid && in_ready_q;
  assign ter_wr = (state_q == S_LOAD_TER) && in_valid && in_ready_q;

  always_comb begin
    ter_bad = 1'b0;
    for (int m = 0; m < 16; m++) begin
      ter_bad = ter_bad | (in_data[2*m +: 2] == 2'b10);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gen_loaded_d = gen_loaded_q;
    ter_loaded_d = ter_loaded_q;
    ter_err_d    = ter_err_q;
    case (state_q)
      S_IDLE: begin
        if (load_gen) begin
          state_d      = S_LOAD_GEN;
          gen_loaded_d = 1'b0;
          cnt_d        = '0;
        end else if (load_ter) begin
          state_d      = S_LOAD_TER;
          ter_loaded_d = 1'b0;
          ter_err_d    = 1'b0;
          cnt_d        = '0;
        end else if (run && gen_loaded_q && ter_loaded_q && mul_ready) begin
          state_d = S_ISSUE;
        end
      end
      S_LOAD_GEN: begin
        if (gen_wr) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GEN_LAST) begin
            state_d      = S_IDLE;
            gen_loaded_d = 1'b1;
          end
        end
      end
      S_LOAD_TER: begin
        if (ter_wr) begin
          cnt_d = cnt_q + 1'b1;
          if (ter_bad) ter_err_d = 1'b1;
          if (cnt_q == TER_LAST) begin
            state_d      = S_IDLE;
            ter_loaded_d = 1'b1;
          end
        end
      end
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!mul_ready) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (mul_ready) state_d = S_FINISH;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    in_ready_d        = (state_d == S_LOAD_GEN) || (state_d == S_LOAD_TER);
    mul_enable_d      = (state_d == S_ISSUE) || (state_d == S_WAIT_BUSY) ||
                        (state_d == S_WAIT_DONE);
    mul_start_d       = (state_d == S_ISSUE);
    mul_rst_command_d = (state_d == S_FINISH);
    done_d            = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      in_ready_q        <= 1'b0;
      gen_loaded_q      <= 1'b0;
      ter_loaded_q      <= 1'b0;
      ter_err_q         <= 1'b0;
      mul_enable_q      <= 1'b0;
      mul_start_q       <= 1'b0;
      mul_rst_command_q <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      in_ready_q        <= in_ready_d;
      gen_loaded_q      <= gen_loaded_d;
      ter_loaded_q      <= ter_loaded_d;
      ter_err_q         <= ter_err_d;
      mul_enable_q      <= mul_enable_d;
      mul_start_q       <= mul_start_d;
      mul_rst_command_q <= mul_rst_command_d;
      done_q            <= done_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign gen_loaded      = gen_loaded_q;
  assign ter_loaded      = ter_loaded_q;
  assign ter_err         = ter_err_q;
  assign mul_enable      = mul_enable_q;
  assign mul_start       = mul_start_q;
  assign mul_rst_command = mul_rst_command_q;
  assign done            = done_q;

  // Inputs may reach 2*Q-1, so one conditional subtract lands them in [0, Q).
  for (genvar gi = 0; gi < PARAM_N; gi++) begin : g_gen
    localparam logic [CW-1:0] WORD = CW'(gi / G);
    localparam int            LANE = gi % G;

    logic [PARAM_LOG_Q-1:0] coef_q, coef_d;
    logic [PARAM_LOG_Q:0]   raw;

    always_comb begin
      raw    = {1'b0, in_data[LANE*PARAM_LOG_Q +: PARAM_LOG_Q]};
      coef_d = coef_q;
      if (gen_wr && (cnt_q == WORD)) begin
        coef_d = (raw >= Q_EXT) ? PARAM_LOG_Q'(raw - Q_EXT) : raw[PARAM_LOG_Q-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) coef_q <= '0;
      else      coef_q <= coef_d;
    end

    assign poly_gen[gi] = coef_q;
  end

  for (genvar gi = 0; gi < PARAM_N; gi++) begin : g_ter
    localparam logic [CW-1:0] WORD = CW'(gi / 16);
    localparam int            LANE = gi % 16;

    logic [1:0] coef_q, coef_d;
    logic [1:0] code;

    always_comb begin
      code   = in_data[2*LANE +: 2];
      coef_d = coef_q;
      if (ter_wr && (cnt_q == WORD)) begin
        coef_d = (code == 2'b10) ? 2'b00 : code;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) coef_q <= '0;
      else      coef_q <= coef_d;
    end

    assign poly_ter[gi] = coef_q;
  end

endmodule
